// File: rtl/vend_ctrl_multi.sv
// Multi-product vending controller: counts one credit per coin press, sells one of
// four products, returns change greedily. Latency: 1 cycle from input edge to
// registered outputs. Change is paid one coin per cycle with no backpressure.
//
// Ports:
//   CLK, RST_N          clock, asynchronous active-low reset
//   Enable              machine power/enable level
//   Coin[3:0]           {100c, 50c, 10c, 5c} debounced levels
//   Select[1:0], Buy    product index and purchase request level
//   Cancel              refund request level
//   Deliver, Product    one-cycle dispense pulse and the product it dispenses
//   Money               current credit in cents
//   ChangeCoin[3:0]     one-hot change pulse, same bit order as Coin
//   Reject              one-cycle pulse when a coin press is discarded
//   Busy                high while vending or paying out change
module vend_ctrl_multi #(
    parameter int CREDIT_W = 8,
    parameter int PRICE0   = 125,
    parameter int PRICE1   = 100,
    parameter int PRICE2   = 75,
    parameter int PRICE3   = 150,
    parameter int TIMEOUT  = 1000
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                Enable,
    input  logic [3:0]          Coin,
    input  logic [1:0]          Select,
    input  logic                Buy,
    input  logic                Cancel,
    output logic                Deliver,
    output logic [1:0]          Product,
    output logic [CREDIT_W-1:0] Money,
    output logic [3:0]          ChangeCoin,
    output logic                Reject,
    output logic                Busy
);

    typedef enum logic [2:0] {
        S_OFF,
        S_READY,
        S_PAYING,
        S_VEND,
        S_CHANGE
    } state_t;

    localparam int MAX_CREDIT = (1 << CREDIT_W) - 1;
    localparam int IDLE_W     = $clog2(TIMEOUT);

    state_t              state;
    logic [CREDIT_W-1:0] credit;
    logic [IDLE_W-1:0]   idle;
    logic [3:0]          coin_q;
    logic                buy_q;
    logic                cancel_q;

    logic                coin_edge;
    logic                buy_edge;
    logic                cancel_edge;
    logic [6:0]          coin_val;
    logic [31:0]         coin_sum;
    logic                coin_ok;
    logic [31:0]         price_sel;
    logic                can_buy;
    logic [CREDIT_W-1:0] buy_rem;
    logic [3:0]          chg_coin;
    logic [31:0]         chg_val;
    logic [CREDIT_W-1:0] chg_rem;
    logic                timed_out;
    state_t              done_state;

    assign coin_edge   = (Coin != 4'b0000) && (coin_q == 4'b0000);
    assign buy_edge    = Buy && !buy_q;
    assign cancel_edge = Cancel && !cancel_q;
    assign timed_out   = (idle == IDLE_W'(TIMEOUT - 1));
    assign done_state  = Enable ? S_READY : S_OFF;
    assign Money       = credit;

    always_comb begin
        coin_val = 7'd0;
        case (Coin)
            4'b1000: coin_val = 7'd100;
            4'b0100: coin_val = 7'd50;
            4'b0010: coin_val = 7'd10;
            4'b0001: coin_val = 7'd5;
            default: coin_val = 7'd0;
        endcase
    end

    // 32-bit arithmetic so overflow and over-range prices compare correctly for any CREDIT_W.
    assign coin_sum = 32'(credit) + 32'(coin_val);
    assign coin_ok  = $onehot(Coin) && (coin_sum <= 32'(MAX_CREDIT));

    always_comb begin
        price_sel = 32'(PRICE0);
        case (Select)
            2'd0: price_sel = 32'(PRICE0);
            2'd1: price_sel = 32'(PRICE1);
            2'd2: price_sel = 32'(PRICE2);
            2'd3: price_sel = 32'(PRICE3);
            default: price_sel = 32'(PRICE0);
        endcase
    end

    assign can_buy = 32'(credit) >= price_sel;
    assign buy_rem = CREDIT_W'(32'(credit) - price_sel);

    // Greedy change step; a residue below the smallest coin is dropped.
    always_comb begin
        chg_coin = 4'b0000;
        chg_val  = 32'd0;
        if (32'(credit) >= 32'd100) begin
            chg_coin = 4'b1000;
            chg_val  = 32'd100;
        end else if (32'(credit) >= 32'd50) begin
            chg_coin = 4'b0100;
            chg_val  = 32'd50;
        end else if (32'(credit) >= 32'd10) begin
            chg_coin = 4'b0010;
            chg_val  = 32'd10;
        end else if (32'(credit) >= 32'd5) begin
            chg_coin = 4'b0001;
            chg_val  = 32'd5;
        end
    end

    assign chg_rem = (chg_val == 32'd0) ? '0 : CREDIT_W'(32'(credit) - chg_val);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= S_OFF;
            credit     <= '0;
            idle       <= '0;
            coin_q     <= 4'b0000;
            buy_q      <= 1'b0;
            cancel_q   <= 1'b0;
            Deliver    <= 1'b0;
            Product    <= 2'd0;
            ChangeCoin <= 4'b0000;
            Reject     <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            coin_q     <= Coin;
            buy_q      <= Buy;
            cancel_q   <= Cancel;
            Deliver    <= 1'b0;
            ChangeCoin <= 4'b0000;
            Reject     <= 1'b0;
            case (state)
                S_OFF: begin
                    Reject <= coin_edge;
                    if (Enable) state <= S_READY;
                end
                S_READY: begin
                    if (!Enable) begin
                        Reject <= coin_edge;
                        state  <= S_OFF;
                    end else if (coin_edge) begin
                        if (coin_ok) begin
                            credit <= coin_sum[CREDIT_W-1:0];
                            idle   <= '0;
                            state  <= S_PAYING;
                        end else begin
                            Reject <= 1'b1;
                        end
                    end
                end
                S_PAYING: begin
                    // Priority: power loss, cancel, affordable buy, timeout, coin.
                    // Any coin press losing to a higher event is rejected.
                    if (!Enable || cancel_edge) begin
                        Reject <= coin_edge;
                        state  <= S_CHANGE;
                        Busy   <= 1'b1;
                    end else if (buy_edge && can_buy) begin
                        Reject  <= coin_edge;
                        credit  <= buy_rem;
                        Product <= Select;
                        Deliver <= 1'b1;
                        state   <= S_VEND;
                        Busy    <= 1'b1;
                    end else if (timed_out) begin
                        Reject <= coin_edge;
                        state  <= S_CHANGE;
                        Busy   <= 1'b1;
                    end else if (coin_edge && coin_ok) begin
                        credit <= coin_sum[CREDIT_W-1:0];
                        idle   <= '0;
                    end else begin
                        Reject <= coin_edge;
                        idle   <= idle + IDLE_W'(1);
                    end
                end
                S_VEND: begin
                    // The first change coin goes out in the cycle right after the dispense pulse.
                    Reject <= coin_edge;
                    if (credit != '0) begin
                        ChangeCoin <= chg_coin;
                        credit     <= chg_rem;
                        if (chg_rem != '0) begin
                            state <= S_CHANGE;
                        end else begin
                            state <= done_state;
                            Busy  <= 1'b0;
                        end
                    end else begin
                        state <= done_state;
                        Busy  <= 1'b0;
                    end
                end
                S_CHANGE: begin
                    Reject     <= coin_edge;
                    ChangeCoin <= chg_coin;
                    credit     <= chg_rem;
                    if (chg_rem == '0) begin
                        state <= done_state;
                        Busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_OFF;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Testbench for vend_ctrl_multi: directed vectors, a cycle-level behavioural model
// compared on every cycle, plus hand-computed literal expectations.
module tb_vend_ctrl_multi;

    localparam int TMO   = 10;
    localparam int MAXC  = 255;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       Enable;
    logic [3:0] Coin;
    logic [1:0] Select;
    logic       Buy;
    logic       Cancel;
    logic       Deliver;
    logic [1:0] Product;
    logic [7:0] Money;
    logic [3:0] ChangeCoin;
    logic       Reject;
    logic       Busy;

    vend_ctrl_multi #(
        .CREDIT_W(8), .PRICE0(125), .PRICE1(100), .PRICE2(75), .PRICE3(150), .TIMEOUT(TMO)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .Enable(Enable), .Coin(Coin), .Select(Select),
        .Buy(Buy), .Cancel(Cancel), .Deliver(Deliver), .Product(Product), .Money(Money),
        .ChangeCoin(ChangeCoin), .Reject(Reject), .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int P_OFF = 0, P_READY = 1, P_PAYING = 2, P_VEND = 3, P_CHANGE = 4;

    int         m_phase;
    int         m_credit;
    int         m_idle;
    int         m_prod;
    int         m_q[$];
    logic [3:0] m_pcoin;
    logic       m_pbuy;
    logic       m_pcancel;
    int         e_del;
    int         e_chg;
    int         e_rej;

    function automatic int cents(input logic [3:0] c);
        case (c)
            4'b1000: return 100;
            4'b0100: return 50;
            4'b0010: return 10;
            4'b0001: return 5;
            default: return 0;
        endcase
    endfunction

    function automatic int bits_of(input int v);
        case (v)
            100: return 8;
            50:  return 4;
            10:  return 2;
            5:   return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int price(input logic [1:0] s);
        case (s)
            2'd0: return 125;
            2'd1: return 100;
            2'd2: return 75;
            default: return 150;
        endcase
    endfunction

    task automatic m_reset();
        m_phase = P_OFF; m_credit = 0; m_idle = 0; m_prod = 0;
        m_q.delete();
        m_pcoin = 4'b0; m_pbuy = 1'b0; m_pcancel = 1'b0;
        e_del = 0; e_chg = 0; e_rej = 0;
    endtask

    // Break the whole credit into the list of coins paid back, largest first.
    task automatic m_plan_refund();
        int c;
        int denoms[4];
        denoms = '{100, 50, 10, 5};
        c = m_credit;
        m_q.delete();
        foreach (denoms[i]) begin
            for (int n = 0; n < c / denoms[i]; n++) m_q.push_back(denoms[i]);
            c = c % denoms[i];
        end
        m_phase = P_CHANGE;
    endtask

    task automatic m_pay_one();
        int v;
        if (m_q.size() > 0) begin
            v = m_q.pop_front();
            e_chg = bits_of(v);
            m_credit -= v;
        end
        if (m_q.size() == 0) begin
            m_credit = 0;
            m_phase = Enable ? P_READY : P_OFF;
        end
    endtask

    task automatic m_step();
        bit ce, be, xe, acc;
        int v;
        ce = (Coin != 4'b0) && (m_pcoin == 4'b0);
        be = Buy && !m_pbuy;
        xe = Cancel && !m_pcancel;
        v = cents(Coin);
        acc = ($countones(Coin) == 1) && (m_credit + v <= MAXC);
        e_del = 0; e_chg = 0; e_rej = 0;
        case (m_phase)
            P_OFF: begin
                e_rej = ce;
                if (Enable) m_phase = P_READY;
            end
            P_READY: begin
                if (!Enable) begin
                    e_rej = ce; m_phase = P_OFF;
                end else if (ce) begin
                    if (acc) begin
                        m_credit += v; m_idle = 0; m_phase = P_PAYING;
                    end else e_rej = 1;
                end
            end
            P_PAYING: begin
                if (!Enable || xe) begin
                    e_rej = ce; m_plan_refund();
                end else if (be && m_credit >= price(Select)) begin
                    e_rej = ce; m_credit -= price(Select); m_prod = Select;
                    e_del = 1; m_phase = P_VEND;
                end else if (m_idle == TMO - 1) begin
                    e_rej = ce; m_plan_refund();
                end else if (ce && acc) begin
                    m_credit += v; m_idle = 0;
                end else begin
                    e_rej = ce; m_idle++;
                end
            end
            P_VEND: begin
                e_rej = ce;
                if (m_credit > 0) begin
                    m_plan_refund(); m_pay_one();
                end else m_phase = Enable ? P_READY : P_OFF;
            end
            default: begin
                e_rej = ce; m_pay_one();
            end
        endcase
        m_pcoin = Coin; m_pbuy = Buy; m_pcancel = Cancel;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge CLK or negedge RST_N);
            if (!RST_N) m_reset();
            else m_step();
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge CLK);
            if (RST_N === 1'b1) begin
                chk("cyc_money", int'(Money), m_credit);
                chk("cyc_deliver", int'(Deliver), e_del);
                chk("cyc_change", int'(ChangeCoin), e_chg);
                chk("cyc_reject", int'(Reject), e_rej);
                chk("cyc_busy", int'(Busy), int'(m_phase == P_VEND || m_phase == P_CHANGE));
                if (e_del != 0) chk("cyc_product", int'(Product), m_prod);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic press(input logic [3:0] c);
        Coin = c; step(1); Coin = 4'b0; step(1);
    endtask

    initial begin
        RST_N = 1'b0; Enable = 1'b0; Coin = 4'b0; Select = 2'd0; Buy = 1'b0; Cancel = 1'b0;
        step(2);
        chk("rst_money", int'(Money), 0);
        chk("rst_deliver", int'(Deliver), 0);
        chk("rst_change", int'(ChangeCoin), 0);
        chk("rst_busy", int'(Busy), 0);
        chk("rst_product", int'(Product), 0);
        RST_N = 1'b1; Enable = 1'b1;
        step(1);

        // Held dollar counts once, then a fifty.
        Coin = 4'b1000; step(1);
        chk("dollar_first", int'(Money), 100);
        step(4);
        chk("dollar_held", int'(Money), 100);
        Coin = 4'b0; step(1);
        Coin = 4'b0100; step(1);
        chk("fifty_added", int'(Money), 150);
        Coin = 4'b0; step(1);

        // Buy product 0 at 125 with 150: dispense, then 10,10,5 change.
        Select = 2'd0; Buy = 1'b1; step(1);
        chk("vend_deliver", int'(Deliver), 1);
        chk("vend_product", int'(Product), 0);
        chk("vend_money", int'(Money), 25);
        Buy = 1'b0; step(1);
        chk("chg1_coin", int'(ChangeCoin), 4'b0010);
        chk("chg1_money", int'(Money), 15);
        step(1);
        chk("chg2_coin", int'(ChangeCoin), 4'b0010);
        step(1);
        chk("chg3_coin", int'(ChangeCoin), 4'b0001);
        chk("chg3_money", int'(Money), 0);
        chk("chg3_busy", int'(Busy), 0);
        step(1);

        // Insufficient credit for product 3, then cancel.
        Coin = 4'b0100; step(1);
        Coin = 4'b0;
        chk("fifty_credit", int'(Money), 50);
        Select = 2'd3; Buy = 1'b1; step(1);
        chk("nobuy_deliver", int'(Deliver), 0);
        chk("nobuy_money", int'(Money), 50);
        Buy = 1'b0; step(1);
        Cancel = 1'b1; step(1);
        chk("cancel_busy", int'(Busy), 1);
        Cancel = 1'b0; step(1);
        chk("cancel_coin", int'(ChangeCoin), 4'b0100);
        chk("cancel_money", int'(Money), 0);
        step(1);

        // Non-one-hot coin and overflow are rejected.
        Coin = 4'b0011; step(1);
        chk("multi_reject", int'(Reject), 1);
        chk("multi_money", int'(Money), 0);
        Coin = 4'b0; step(1);
        press(4'b1000); press(4'b1000); press(4'b0100);
        chk("credit_250", int'(Money), 250);
        Coin = 4'b0011; step(1);
        chk("multi2_reject", int'(Reject), 1);
        Coin = 4'b0; step(1);
        Coin = 4'b0100; step(1);
        chk("ovf_reject", int'(Reject), 1);
        chk("ovf_money", int'(Money), 250);
        Coin = 4'b0; step(1);
        Cancel = 1'b1; step(1);
        Cancel = 1'b0; step(4);
        chk("refund250_money", int'(Money), 0);

        // Inactivity timeout with 15 cents.
        Coin = 4'b0010; step(1);
        Coin = 4'b0; step(1);
        Coin = 4'b0001; step(1);
        chk("tmo_credit", int'(Money), 15);
        Coin = 4'b0; step(TMO);
        chk("tmo_idle_chg", int'(ChangeCoin), 0);
        chk("tmo_busy", int'(Busy), 1);
        step(1);
        chk("tmo_coin1", int'(ChangeCoin), 4'b0010);
        chk("tmo_money1", int'(Money), 5);
        step(1);
        chk("tmo_coin2", int'(ChangeCoin), 4'b0001);
        chk("tmo_money2", int'(Money), 0);
        step(1);

        // Enable dropped with 60 cents: refund then power off.
        press(4'b0100);
        Coin = 4'b0010; step(1);
        chk("credit_60", int'(Money), 60);
        Coin = 4'b0; step(1);
        Enable = 1'b0; step(1);
        chk("off_busy", int'(Busy), 1);
        step(1);
        chk("off_coin1", int'(ChangeCoin), 4'b0100);
        chk("off_money1", int'(Money), 10);
        step(1);
        chk("off_coin2", int'(ChangeCoin), 4'b0010);
        chk("off_money2", int'(Money), 0);
        step(1);
        Coin = 4'b1000; step(1);
        chk("off_reject", int'(Reject), 1);
        chk("off_money", int'(Money), 0);
        Coin = 4'b0; step(1);

        // Reset in the middle of a refund.
        Enable = 1'b1; step(1);
        press(4'b1000); press(4'b0100);
        Cancel = 1'b1; step(1);
        Cancel = 1'b0; step(1);
        chk("pre_rst_coin", int'(ChangeCoin), 4'b1000);
        chk("pre_rst_money", int'(Money), 50);
        #1 RST_N = 1'b0;
        #1;
        chk("midrst_money", int'(Money), 0);
        chk("midrst_change", int'(ChangeCoin), 0);
        chk("midrst_busy", int'(Busy), 0);
        chk("midrst_deliver", int'(Deliver), 0);
        chk("midrst_reject", int'(Reject), 0);
        step(1);
        RST_N = 1'b1;
        step(3);
        chk("post_rst_money", int'(Money), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vend_ctrl_multi.md
# vend_ctrl_multi

Parametrised multi-product vending controller. It accepts pre-debounced coin levels and counts exactly one credit per press. It sells one of four products at per-product prices and returns change greedily as one coin pulse per cycle. It also supports cancel/refund, an inactivity timeout and power-down refund. It sits between the per-button debouncers and the dispenser/coin-return actuators.

## Interface
- CREDIT_W, 8: credit register width; max credit 2^CREDIT_W-1.
- PRICE0, 125: price of product 0, in cents.
- PRICE1, 100: price of product 1.
- PRICE2, 75: price of product 2.
- PRICE3, 150: price of product 3.
- TIMEOUT, 1000: idle cycles in PAYING before auto-refund; must be ≥2.
- CLK  in  1  single clock; all state changes on its rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- Enable  in  1  machine power/enable level.
- Coin  in  4  {OneDollar, FiftyCents, TenCents, FiveCents} levels, debounced, held while pressed.
- Select  in  2  product index, sampled on Buy edge.
- Buy  in  1  purchase request level.
- Cancel  in  1  refund request level.
- Deliver  out  1  one-cycle dispense pulse.
- Product  out  2  product index latched at purchase; valid while Deliver=1.
- Money  out  CREDIT_W  current credit in cents.
- ChangeCoin  out  4  one-hot change pulse, same bit order as Coin.
- Reject  out  1  one-cycle pulse: coin input discarded.
- Busy  out  1  high in VEND and CHANGE.

## Operation
- States: OFF, READY (credit 0), PAYING (credit>0), VEND, CHANGE.
- Reset (RST_N=0, immediate): state OFF. Credit, Deliver, Product, ChangeCoin, Reject and Busy are 0; idle counter 0. Edge-detect registers load 0.
- Events are rising edges of Coin (value ≠0 and previous sample =0), Buy and Cancel. Edge detection is internal, with one register per input. A held input never retriggers.
- Coin edge value must be one-hot. Otherwise Reject pulses and no credit is given.
- Coin values: 100/50/10/5.
- OFF→READY when Enable=1. Coin edges in OFF, VEND and CHANGE pulse Reject.
- READY/PAYING coin edge: credit += value, state → PAYING.
  - If credit+value > 2^CREDIT_W-1: Reject pulses and credit is unchanged.
- PAYING Buy edge:
  - If credit ≥ PRICE[Select]: credit -= price, Product ← Select, state → VEND.
  - Otherwise the edge is ignored; no pulse, credit unchanged.
- VEND: Deliver=1 for exactly one cycle. Next state is CHANGE if credit>0, else READY.
- Buy edge in READY is ignored.
- PAYING Cancel edge → CHANGE with the full credit.
- Idle counter: cleared on any accepted coin edge or on entry to PAYING. Increments each PAYING cycle. At TIMEOUT-1 it forces CHANGE (refund).
- CHANGE: each cycle pulses ChangeCoin for the largest coin ≤ credit (100, 50, 10, 5), and credit decreases by that value.
  - When credit reaches 0: → READY, or → OFF if Enable=0.
  - A residue <5 is returned as nothing and credit is cleared. Unreachable with the fixed coin set, but required.
- Enable=0 in READY → OFF. Enable=0 in PAYING → CHANGE (full refund), then OFF.
- Enable=0 during VEND or CHANGE: the current sequence completes, then OFF.
- Same-cycle priority in PAYING: Enable low > Cancel > Buy > timeout > coin. A coin edge that loses to another event pulses Reject.
- Prices >2^CREDIT_W-1 make that product unpurchasable. This is legal and not an error.

## Timing
- Input sampled at edge n produces its response after edge n. Money, state, Reject and ChangeCoin are registered outputs.
- Coin edge first sampled at edge n: Money = new credit from edge n onward. Latency is 1 cycle.
- Buy edge at n: VEND from n, Deliver=1 for cycle n..n+1, and Money shows the remaining credit during that cycle.
- First change pulse occurs in the cycle after VEND. Change takes one pulse per coin, back-to-back, with no gaps.
- Cancel at n: first ChangeCoin pulse occurs in the cycle after CHANGE is entered at n.
- Busy = (state==VEND || state==CHANGE), registered with the state.
- Reset assertion mid-CHANGE aborts the refund and drops the credit. This is acceptable by design.

## Test plan
- Reset, Enable=1, OneDollar held 5 cycles then FiftyCents edge → Money=100 after first edge (no retrigger), then Money=150.
- Credit 150, Select=0, Buy edge → Deliver pulse with Product=0, Money=25. Then ChangeCoin 0010, 0010, 0001 over 3 consecutive cycles. Money=0, then READY.
- Credit 50, Select=3, Buy edge → no Deliver, Money stays 50. Then Cancel edge → ChangeCoin=0100 for one cycle, Money=0.
- Coin=0011 edge → Reject pulse, Money unchanged. Credit 250 plus FiftyCents edge → Reject, Money stays 250.
- TIMEOUT=10, credit 15, no events → after 10 PAYING cycles ChangeCoin 0010 then 0001, then READY.
- Credit 60, Enable dropped → refund 0100 then 0010, then OFF. Coin edge in OFF → Reject. RST_N low mid-CHANGE → all outputs 0 immediately.
